mole_round_controller: RTL and testbench
========================================

# mole_round_controller

Round sequencer for the Whac-A-Mole game: owns the game state machine, generates pseudo-random `mole_positions` for `hit_logic`, times each mole-up window and the gap between rounds, and tracks lives and level from `hit_logic`'s `miss` / `full_clear_hit` results. It drives `game_in_progress` and `mole_positions` into `hit_logic` and exposes lives, level and game-over status to the display logic.

## Interface
- `NUM_HOLES`, 18, number of holes / switches / LEDs
- `CLKS_PER_MS`, 50_000, clk cycles per 1 ms tick (50 MHz)
- `GAP_MS`, 300, ms with all holes empty between rounds
- `BASE_UP_MS`, 2000, mole-up window at level 0
- `MIN_UP_MS`, 400, floor of the mole-up window
- `STEP_MS`, 100, window reduction per level gained
- `MAX_LIVES`, 3, lives at game start (1..15)
- `LFSR_SEED`, 24'hACE1B5, LFSR reset value, must be nonzero

Ports:
- `clk` in 1: system clock, 50 MHz
- `reset` in 1: asynchronous, active-high reset
- `start` in 1: start/restart request, one-cycle pulse from the debounced key
- `miss` in 1: from `hit_logic`, level or pulse
- `full_clear_hit` in 1: from `hit_logic`, all current moles hit
- `mole_positions` out NUM_HOLES: active mole mask, registered
- `game_in_progress` out 1: high in GAP and UP
- `lives` out 4: remaining lives
- `level` out 5: rounds fully cleared, saturates at 31
- `game_over` out 1: high in OVER

## Operation
- States: IDLE, GAP, UP, OVER.
- IDLE: outputs idle. `start` → GAP, `lives`=MAX_LIVES, `level`=0, up window=BASE_UP_MS.
- GAP: `mole_positions`=0. After GAP_MS → UP, loading the pattern.
- Pattern: `lfsr[NUM_HOLES-1:0] & lfsr[NUM_HOLES+5:6]` (≈25% density). If zero, bit 0 is forced to 1. Never zero in UP.
- LFSR: 24-bit Fibonacci, taps 24,23,22,17. Advances every clk in every state, so patterns depend on start time.
- UP: `mole_positions` is held constant.
  - `full_clear_hit` → `level`+1 (saturating), up window = max(window−STEP_MS, MIN_UP_MS) → GAP.
  - Window expiry without clear → lose a life → GAP, or OVER if `lives` reaches 0.
- `miss`: rising-edge detected internally. Each edge in GAP or UP loses one life; reaching 0 → OVER.
- Life loss: at most one per cycle. A miss edge coinciding with a timeout costs one life. `lives` never underflows.
- `full_clear_hit` coinciding with window expiry: the hit wins, no life lost. A miss edge in that same cycle still costs a life.
- OVER: `mole_positions`=0, `game_in_progress`=0, `game_over`=1. `level` is held for display. `start` → GAP with a full reinit, as from IDLE.
- `start` in GAP or UP is ignored.
- Inputs are ignored in IDLE and OVER.

## Timing
- Reset values: state IDLE, `mole_positions` 0, `game_in_progress` 0, `lives` 0, `level` 0, `game_over` 0, LFSR=LFSR_SEED, timers 0. Reset is effective immediately, without a clock edge.
- All outputs are registered and change on the clk edge that performs the transition.
- `start` sampled at edge N → `game_in_progress`=1 and `lives`=MAX_LIVES after edge N.
- Prescaler and ms counter clear on every state entry. GAP lasts exactly GAP_MS·CLKS_PER_MS cycles. UP lasts exactly window·CLKS_PER_MS cycles unless it is cut short.
- `full_clear_hit` or a miss edge sampled at edge N takes effect on outputs after edge N.
- The miss edge detector register resets to 0 and is cleared on entry to GAP from IDLE/OVER. A `miss` held high therefore costs one life.
- Window arithmetic uses 16-bit ms values, with saturation at MIN_UP_MS and no wrap.

## Structure
- Package `whac_pkg`: state enum (IDLE/GAP/UP/OVER), default `NUM_HOLES`, LFSR width and tap constants.
- Sub-module `ms_timer`: prescaler to a 1 ms tick plus a 16-bit ms down-counter, with `load`, `load_value` and `expired` (one-cycle pulse) ports.
- FSM, LFSR, lives and level live in the top module.

## Test plan
Parameters: CLKS_PER_MS=4, GAP_MS=2, BASE_UP_MS=5, STEP_MS=1, MIN_UP_MS=3, MAX_LIVES=3.
- **Reset/start:** assert `reset` mid-sim → all outputs 0 with no clk. Pulse `start` → next cycle `game_in_progress`=1, `lives`=3. `mole_positions` goes nonzero exactly 8 cycles after GAP entry.
- **Clears:** `full_clear_hit` in UP → next cycle `mole_positions`=0, `level`=1. Next UP lasts 16 cycles. Further clears give windows of 12, then 12 (floor).
- **Timeouts:** no hits → UP expires after 20 cycles, `lives`=2. Third timeout → `game_over`=1, `game_in_progress`=0, `mole_positions`=0, `level` held.
- **Held miss:** `miss` held high 10 cycles in UP → `lives` decrements by exactly 1. A second rising edge → one more life lost.
- **Hit/expiry race:** `full_clear_hit` on the expiry cycle → `level`+1, `lives` unchanged. Miss edge plus timeout in the same cycle → `lives` −1 only.
- **Restart and ignored start:** `start` in OVER → `lives`=3, `level`=0, GAP. `start` during UP → no effect.

Source files
------------

// File: rtl/whac_pkg.sv
// Shared definitions for the Whac-A-Mole round sequencer.
// Contents:
//   state_t           - round sequencer states (IDLE, GAP, UP, OVER)
//   DEFAULT_NUM_HOLES - default hole / switch / LED count
//   LFSR_WIDTH        - width of the pattern LFSR
//   LFSR_TAPS         - feedback tap mask (taps 24,23,22,17 in 1-based numbering)
//   lfsr_next()       - one Fibonacci LFSR step
package whac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int DEFAULT_NUM_HOLES = 18;
    localparam int LFSR_WIDTH        = 24;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 24'hE1_0000;

    // Shift left and feed the XOR of the tapped bits into bit 0.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] cur);
        return {cur[LFSR_WIDTH-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mole_round_controller_ms_timer.sv
// Millisecond interval timer: a prescaler producing a 1 ms tick and a 16-bit
// ms down-counter.
// Ports:
//   clk        in  - system clock
//   reset      in  - asynchronous active-high reset
//   load       in  - clear the prescaler and load the ms counter
//   load_value in  - interval length in ms (0 never expires)
//   expired    out - one-cycle pulse in the last clock cycle of the interval
module ms_timer #(
    parameter int CLKS_PER_MS = 50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic        expired
);

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);

    logic [PW-1:0] presc_r;
    logic [15:0]   ms_r;
    logic          tick_s;

    assign tick_s = (presc_r == PRESC_MAX);

    // Expiry is decoded from the registers so that the owner can change state
    // on the very edge that ends the interval, giving exact cycle counts.
    assign expired = tick_s && (ms_r == 16'd1);

    // Prescaler and ms down-counter; load restarts both from a clean boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r <= '0;
            ms_r    <= 16'd0;
        end else if (load) begin
            presc_r <= '0;
            ms_r    <= load_value;
        end else if (tick_s) begin
            presc_r <= '0;
            if (ms_r != 16'd0) begin
                ms_r <= ms_r - 16'd1;
            end else begin
                ms_r <= ms_r;
            end
        end else begin
            presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
            ms_r    <= ms_r;
        end
    end

endmodule

// File: rtl/mole_round_controller.sv
// Round sequencer for Whac-A-Mole: game FSM, pseudo-random mole patterns,
// mole-up / inter-round timing, lives and level bookkeeping.
// Ports:
//   clk              in  - system clock
//   reset            in  - asynchronous active-high reset
//   start            in  - start/restart pulse (honoured in IDLE and OVER only)
//   miss             in  - miss indication from hit_logic (level or pulse)
//   full_clear_hit   in  - all current moles hit
//   mole_positions   out - active mole mask (nonzero only in UP)
//   game_in_progress out - high in GAP and UP
//   lives            out - remaining lives
//   level            out - rounds fully cleared, saturating at 31
//   game_over        out - high in OVER
// All outputs are registered. NUM_HOLES must be 2..18 so that the pattern
// slice lfsr[NUM_HOLES+5:6] stays inside the 24-bit LFSR.
module mole_round_controller
    import whac_pkg::*;
#(
    parameter int          NUM_HOLES   = DEFAULT_NUM_HOLES,
    parameter int          CLKS_PER_MS = 50_000,
    parameter int          GAP_MS      = 300,
    parameter int          BASE_UP_MS  = 2000,
    parameter int          MIN_UP_MS   = 400,
    parameter int          STEP_MS     = 100,
    parameter int          MAX_LIVES   = 3,
    parameter logic [23:0] LFSR_SEED   = 24'hACE1B5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 miss,
    input  logic                 full_clear_hit,
    output logic [NUM_HOLES-1:0] mole_positions,
    output logic                 game_in_progress,
    output logic [3:0]           lives,
    output logic [4:0]           level,
    output logic                 game_over
);

    localparam logic [15:0] GAP_W     = 16'(GAP_MS);
    localparam logic [15:0] BASE_UP_W = 16'(BASE_UP_MS);
    localparam logic [15:0] MIN_UP_W  = 16'(MIN_UP_MS);
    localparam logic [15:0] STEP_W    = 16'(STEP_MS);
    localparam logic [16:0] SHRINK_LIMIT = {1'b0, MIN_UP_W} + {1'b0, STEP_W};
    localparam logic [3:0]  MAX_LIVES_W  = 4'(MAX_LIVES);

    state_t                  state_r, state_s;
    logic [LFSR_WIDTH-1:0]   lfsr_r;
    logic                    miss_d_r;
    logic [15:0]             window_r, window_s;
    logic [3:0]              lives_s;
    logic [4:0]              level_s;
    logic [NUM_HOLES-1:0]    mole_s, raw_pattern_s, pattern_s;
    logic                    miss_edge_s, lose_life_s, timer_expired_s;
    logic                    load_s, new_game_s;
    logic [15:0]             load_value_s;

    assign miss_edge_s = miss & ~miss_d_r;
    assign new_game_s  = ((state_r == IDLE) || (state_r == OVER)) && (state_s == GAP);

    ms_timer #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_value (load_value_s),
        .expired    (timer_expired_s)
    );

    // Sparse pattern (AND of two LFSR slices); never allowed to be empty.
    always_comb begin
        raw_pattern_s = lfsr_r[NUM_HOLES-1:0] & lfsr_r[NUM_HOLES+5:6];
        if (raw_pattern_s == '0) begin
            pattern_s = {{(NUM_HOLES-1){1'b0}}, 1'b1};
        end else begin
            pattern_s = raw_pattern_s;
        end
    end

    // Next state, lives, level, window, mole mask and timer reload.
    always_comb begin
        state_s      = state_r;
        lives_s      = lives;
        level_s      = level;
        window_s     = window_r;
        mole_s       = mole_positions;
        lose_life_s  = 1'b0;
        load_s       = 1'b0;
        load_value_s = 16'd0;

        case (state_r)
            IDLE, OVER: begin
                if (start) begin
                    state_s  = GAP;
                    lives_s  = MAX_LIVES_W;
                    level_s  = 5'd0;
                    window_s = BASE_UP_W;
                end else begin
                    state_s = state_r;
                end
            end
            GAP: begin
                if (timer_expired_s) begin
                    state_s = UP;
                    mole_s  = pattern_s;
                end else begin
                    state_s = GAP;
                end
                lose_life_s = miss_edge_s;
            end
            UP: begin
                // A clear wins over a simultaneous expiry; a miss edge in the
                // same cycle still costs its life.
                if (full_clear_hit) begin
                    state_s     = GAP;
                    lose_life_s = miss_edge_s;
                    if (level == 5'd31) begin
                        level_s = 5'd31;
                    end else begin
                        level_s = level + 5'd1;
                    end
                    if ({1'b0, window_r} >= SHRINK_LIMIT) begin
                        window_s = window_r - STEP_W;
                    end else begin
                        window_s = MIN_UP_W;
                    end
                end else if (timer_expired_s) begin
                    state_s     = GAP;
                    lose_life_s = 1'b1;
                end else begin
                    state_s     = UP;
                    lose_life_s = miss_edge_s;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // One life at most per cycle; the last one ends the game.
        if (lose_life_s) begin
            if (lives_s > 4'd1) begin
                lives_s = lives_s - 4'd1;
            end else begin
                lives_s = 4'd0;
                state_s = OVER;
            end
        end else begin
            lives_s = lives_s;
        end

        // Every state entry restarts the timer with that state's interval.
        if (state_s != state_r) begin
            load_s = 1'b1;
            if (state_s == GAP) begin
                load_value_s = GAP_W;
            end else if (state_s == UP) begin
                load_value_s = window_r;
            end else begin
                load_value_s = 16'd0;
            end
        end else begin
            load_s = 1'b0;
        end

        if (state_s != UP) begin
            mole_s = '0;
        end else begin
            mole_s = mole_s;
        end
    end

    // State, LFSR, miss edge history and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= IDLE;
            lfsr_r           <= LFSR_SEED;
            miss_d_r         <= 1'b0;
            window_r         <= 16'd0;
            lives            <= 4'd0;
            level            <= 5'd0;
            mole_positions   <= '0;
            game_in_progress <= 1'b0;
            game_over        <= 1'b0;
        end else begin
            state_r  <= state_s;
            lfsr_r   <= lfsr_next(lfsr_r);
            // Clearing on a new game makes a miss that is already high count once.
            if (new_game_s) begin
                miss_d_r <= 1'b0;
            end else begin
                miss_d_r <= miss;
            end
            window_r         <= window_s;
            lives            <= lives_s;
            level            <= level_s;
            mole_positions   <= mole_s;
            game_in_progress <= (state_s == GAP) || (state_s == UP);
            game_over        <= (state_s == OVER);
        end
    end

endmodule

// File: tb/tb_mole_round_controller.sv
// Bench for mole_round_controller with fast timing (4 clk/ms, GAP 2 ms,
// window 5 ms shrinking by 1 ms to a 3 ms floor, 3 lives).
module tb_mole_round_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        miss = 1'b0;
    logic        full_clear_hit = 1'b0;
    logic [17:0] mole_positions;
    logic        game_in_progress;
    logic [3:0]  lives;
    logic [4:0]  level;
    logic        game_over;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] cyc;
        logic [3:0] lives;
        logic [4:0] level;
        logic       gip;
        logic       over;
        logic       mole_nz;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  e;
    obs_t got;

    mole_round_controller #(
        .NUM_HOLES   (18),
        .CLKS_PER_MS (4),
        .GAP_MS      (2),
        .BASE_UP_MS  (5),
        .MIN_UP_MS   (3),
        .STEP_MS     (1),
        .MAX_LIVES   (3),
        .LFSR_SEED   (24'hACE1B5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .miss             (miss),
        .full_clear_hit   (full_clear_hit),
        .mole_positions   (mole_positions),
        .game_in_progress (game_in_progress),
        .lives            (lives),
        .level            (level),
        .game_over        (game_over)
    );

    always #5 clk = ~clk;

    function automatic sb_t mk(input string tag, input int cyc, input int lv, input int lvl,
                               input int gip, input int over, input int mnz);
        sb_t s;
        s.tag       = tag;
        s.v.cyc     = 8'(cyc);
        s.v.lives   = 4'(lv);
        s.v.level   = 5'(lvl);
        s.v.gip     = 1'(gip);
        s.v.over    = 1'(over);
        s.v.mole_nz = 1'(mnz);
        return s;
    endfunction

    function automatic obs_t snap(input int cyc);
        obs_t o;
        o.cyc     = 8'(cyc);
        o.lives   = lives;
        o.level   = level;
        o.gip     = game_in_progress;
        o.over    = game_over;
        o.mole_nz = (mole_positions != 18'd0);
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("cyc=%0d lives=%0d level=%0d gip=%0b over=%0b mole_nz=%0b",
                         o.cyc, o.lives, o.level, o.gip, o.over, o.mole_nz);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until mole_positions nonzero-ness equals want_nz, bounded.
    task automatic run_until(input logic want_nz, output int n);
        n = 0;
        while (((mole_positions != 18'd0) != want_nz) && (n < 200)) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        sb_q.push_back(mk("reset_state", 0, 0, 0, 0, 0, 0));
        e = sb_q.pop_front(); got = snap(0); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_start();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb_q.push_back(mk("start_gap", 0, 3, 0, 1, 0, 0));
        e = sb_q.pop_front(); got = snap(0); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
        sb_q.push_back(mk("gap_length", 8, 3, 0, 1, 0, 1));
        run_until(1'b1, n);
        e = sb_q.pop_front(); got = snap(n); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
    endtask

    // Lets the current UP window time out; checks the mask never changes.
    task automatic measure_timeout(input string tag, input int cyc, input int lv, input int lvl,
                                   input int gip, input int over);
        int n;
        logic [17:0] pat;
        logic held;
        sb_q.push_back(mk(tag, cyc, lv, lvl, gip, over, 0));
        pat  = mole_positions;
        held = 1'b1;
        n    = 0;
        while ((mole_positions != 18'd0) && (n < 200)) begin
            tick();
            n++;
            if ((mole_positions != 18'd0) && (mole_positions != pat)) held = 1'b0;
        end
        e = sb_q.pop_front(); got = snap(n); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
        checks++;
        if (held !== 1'b1) begin failures++; $display("FAIL %s_mask_held got %0b expected 1", tag, held); end
    endtask

    task automatic test_timeout();
        measure_timeout("timeout_w20", 20, 2, 0, 1, 0);
    endtask

    task automatic test_clears();
        int n;
        sb_q.push_back(mk("gap_after_timeout", 8, 2, 0, 1, 0, 1));
        run_until(1'b1, n);
        e = sb_q.pop_front(); got = snap(n); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
        full_clear_hit = 1'b1;
        sb_q.push_back(mk("clear_immediate", 0, 2, 1, 1, 0, 0));
        tick();
        full_clear_hit = 1'b0;
        e = sb_q.pop_front(); got = snap(0); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
    endtask

    // Clears land exactly on the expiry edge: window 16 then 12 cycles.
    task automatic test_hit_race();
        int n;
        int win [2] = '{16, 12};
        for (int r = 0; r < 2; r++) begin
            run_until(1'b1, n);
            repeat (win[r] - 1) tick();
            sb_q.push_back(mk($sformatf("still_up_before_expiry_%0d", r), 0, 2, 1 + r, 1, 0, 1));
            e = sb_q.pop_front(); got = snap(0); checks++;
            if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
            full_clear_hit = 1'b1;
            sb_q.push_back(mk($sformatf("hit_on_expiry_%0d", r), 0, 2, 2 + r, 1, 0, 0));
            tick();
            full_clear_hit = 1'b0;
            e = sb_q.pop_front(); got = snap(0); checks++;
            if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
        end
    endtask

    task automatic test_floor_and_over();
        int n;
        run_until(1'b1, n);
        measure_timeout("timeout_floor_w12", 12, 1, 3, 1, 0);
        run_until(1'b1, n);
        measure_timeout("third_timeout_over", 12, 0, 3, 0, 1);
        miss = 1'b1;
        full_clear_hit = 1'b1;
        repeat (3) tick();
        miss = 1'b0;
        full_clear_hit = 1'b0;
        sb_q.push_back(mk("over_ignores_inputs", 0, 0, 3, 0, 1, 0));
        tick();
        e = sb_q.pop_front(); got = snap(0); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
    endtask

    task automatic test_restart();
        int n;
        start = 1'b1;
        sb_q.push_back(mk("restart_from_over", 0, 3, 0, 1, 0, 0));
        tick();
        start = 1'b0;
        e = sb_q.pop_front(); got = snap(0); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
        run_until(1'b1, n);
        checks++;
        if (n !== 8) begin failures++; $display("FAIL restart_gap_length got %0d expected 8", n); end
    endtask

    // Start ignored in UP, held miss costs one life, miss edge + timeout costs one.
    task automatic test_miss_and_start();
        logic [17:0] pat;
        pat = mole_positions;
        start = 1'b1;
        tick();
        start = 1'b0;
        miss = 1'b1;
        repeat (10) tick();
        miss = 1'b0;
        sb_q.push_back(mk("held_miss_one_life", 0, 2, 0, 1, 0, 1));
        e = sb_q.pop_front(); got = snap(0); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
        repeat (8) tick();
        checks++;
        if (mole_positions !== pat) begin
            failures++;
            $display("FAIL start_ignored_in_up got %h expected %h", mole_positions, pat);
        end
        miss = 1'b1;
        sb_q.push_back(mk("miss_plus_timeout", 0, 1, 0, 1, 0, 0));
        tick();
        e = sb_q.pop_front(); got = snap(0); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
        miss = 1'b0;
        tick();
        miss = 1'b1;
        sb_q.push_back(mk("second_edge_over", 0, 0, 0, 0, 1, 0));
        tick();
        miss = 1'b0;
        e = sb_q.pop_front(); got = snap(0); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
    endtask

    task automatic test_mid_reset();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(1'b1, n);
        sb_q.push_back(mk("async_reset_no_clk", 0, 0, 0, 0, 0, 0));
        #2;
        reset = 1'b1;
        #1;
        e = sb_q.pop_front(); got = snap(0); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
        #1;
        reset = 1'b0;
        sb_q.push_back(mk("idle_after_reset", 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        e = sb_q.pop_front(); got = snap(0); checks++;
        if (got !== e.v) begin failures++; $display("FAIL %s got %s expected %s", e.tag, fmt(got), fmt(e.v)); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_timeout();
        test_clears();
        test_hit_race();
        test_floor_and_over();
        test_restart();
        test_miss_and_start();
        test_restart();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
